// File: rtl/fft_result_unloader.sv
// ----------------------------------------------------------------------------
// fft_result_unloader
//
// Streams the 32 complex results of a finished FFT out of a two-bank sample
// memory in natural bin order. The memory holds results in bit-reversed
// order, so with BITREV=1 the read address is the bit-reversal of the bin
// counter. Read data arrives one cycle after the strobe and is parked in a
// 2-entry FIFO so a ready/valid consumer can stall without losing samples.
//
// Ports
//   clk          rising-edge clock
//   sclr         synchronous active-high reset, highest priority
//   fft_done     level from the FFT engine; a rising edge starts an unload
//   bank_select  bank holding the results, latched at start
//   rd_en        memory read strobe
//   rd_bank      bank being read (constant for a whole unload)
//   rd_address   memory word address 0..31
//   rd_data      read data, valid one cycle after rd_en
//   out_valid    output sample valid
//   out_ready    downstream accepts the sample
//   out_data     bin value (real upper half, imaginary lower half)
//   out_index    natural-order bin number of out_data
//   out_last     marks bin 31
//   busy         unload in progress
//   unload_done  one-cycle pulse after bin 31 is accepted
// ----------------------------------------------------------------------------
module fft_result_unloader #(
    parameter int DATA_W = 32,
    parameter bit BITREV = 1'b1
) (
    input  logic              clk,
    input  logic              sclr,
    input  logic              fft_done,
    input  logic              bank_select,
    output logic              rd_en,
    output logic              rd_bank,
    output logic [4:0]        rd_address,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_index,
    output logic              out_last,
    output logic              busy,
    output logic              unload_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              fft_done_q;
    logic              rd_bank_q;
    logic [4:0]        k_q;
    logic              inflight_q;
    logic [4:0]        inflight_idx_q;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [4:0]        fifo_idx_q  [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic              unload_done_q;

    logic              start;
    logic              pop;
    logic              head_last;
    logic              room;

    assign start     = fft_done & ~fft_done_q;
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid & out_ready;
    assign head_last = (fifo_idx_q[rd_ptr_q] == 5'd31);

    // Reads already in flight must also have a FIFO slot waiting for them;
    // a pop this cycle frees one slot in time for the next capture.
    assign room = (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    assign count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: combinational blocks assign a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)                      state_d = READ;
            READ:    if (rd_en && (k_q == 5'd31))    state_d = DRAIN;
            DRAIN:   if (pop && head_last)           state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b0;
        unique case (state_q)
            IDLE:    ;
            READ:    begin rd_en = room; busy = 1'b1; end
            DRAIN:   busy = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: counter, read pipeline, output FIFO
    // ------------------------------------------------------------------
    // NOTE: the FIFO storage is reset as well because out_data and
    // out_index are read straight from the head entry and must be zero
    // after reset.
    always_ff @(posedge clk) begin
        if (sclr) begin
            fft_done_q     <= 1'b1;  // a level already high at release is not an edge
            rd_bank_q      <= 1'b0;
            k_q            <= 5'd0;
            inflight_q     <= 1'b0;  // drops any read already issued
            inflight_idx_q <= 5'd0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_idx_q[0]  <= 5'd0;
            fifo_idx_q[1]  <= 5'd0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= 2'd0;
            unload_done_q  <= 1'b0;
        end else begin
            fft_done_q <= fft_done;

            if ((state_q == IDLE) && start) begin
                rd_bank_q <= bank_select;
                k_q       <= 5'd0;
            end else if (rd_en && (k_q != 5'd31)) begin
                // k stays at 31 after the final read so the address holds
                k_q <= k_q + 5'd1;
            end

            inflight_q     <= rd_en;
            inflight_idx_q <= k_q;

            if (inflight_q) begin
                fifo_data_q[wr_ptr_q] <= rd_data;
                fifo_idx_q[wr_ptr_q]  <= inflight_idx_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;

            unload_done_q <= pop & head_last & (state_q == DRAIN);
        end
    end

    assign rd_bank     = rd_bank_q;
    assign rd_address  = BITREV ? {k_q[0], k_q[1], k_q[2], k_q[3], k_q[4]} : k_q;
    assign out_data    = fifo_data_q[rd_ptr_q];
    assign out_index   = fifo_idx_q[rd_ptr_q];
    assign out_last    = out_valid & head_last;
    assign unload_done = unload_done_q;

endmodule

// File: tb/tb_fft_result_unloader.sv
// ----------------------------------------------------------------------------
// tb_fft_result_unloader
//
// Directed bench for fft_result_unloader. Two instances share all inputs:
// one reads bit-reversed (BITREV=1), the other linearly (BITREV=0). Each has
// its own two-bank memory model: bank 1 word a = 0x1000+a, bank 0 word
// a = 0x2000+a, returned one cycle after the read strobe.
// ----------------------------------------------------------------------------
module tb_fft_result_unloader;

    logic        clk = 1'b0;
    logic        sclr;
    logic        fft_done;
    logic        bank_select;
    logic        out_ready;

    logic        rd_en,   rd_en_l;
    logic        rd_bank, rd_bank_l;
    logic [4:0]  rd_address, rd_address_l;
    logic [31:0] rd_data, rd_data_l;
    logic        out_valid, out_valid_l;
    logic [31:0] out_data, out_data_l;
    logic [4:0]  out_index, out_index_l;
    logic        out_last, out_last_l;
    logic        busy, busy_l;
    logic        unload_done, unload_done_l;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fft_result_unloader #(.DATA_W(32), .BITREV(1'b1)) dut (
        .clk(clk), .sclr(sclr), .fft_done(fft_done), .bank_select(bank_select),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_address(rd_address), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy),
        .unload_done(unload_done)
    );

    fft_result_unloader #(.DATA_W(32), .BITREV(1'b0)) dut_lin (
        .clk(clk), .sclr(sclr), .fft_done(fft_done), .bank_select(bank_select),
        .rd_en(rd_en_l), .rd_bank(rd_bank_l), .rd_address(rd_address_l), .rd_data(rd_data_l),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
        .out_index(out_index_l), .out_last(out_last_l), .busy(busy_l),
        .unload_done(unload_done_l)
    );

    // Memory models
    always @(posedge clk) begin
        if (rd_en)   rd_data   <= (rd_bank   ? 32'h1000 : 32'h2000) + {27'd0, rd_address};
        if (rd_en_l) rd_data_l <= (rd_bank_l ? 32'h1000 : 32'h2000) + {27'd0, rd_address_l};
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] bitrev5(input logic [4:0] v);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = v[4-i];
        return r;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check(tag, {16'd0, rd_en, rd_address, rd_bank, out_valid, out_data, out_index,
                    out_last, busy, unload_done}, 64'd0);
        check({tag, "_lin"}, {16'd0, rd_en_l, rd_address_l, rd_bank_l, out_valid_l, out_data_l,
                    out_index_l, out_last_l, busy_l, unload_done_l}, 64'd0);
    endtask

    // Drops fft_done for one cycle, raises it (cycle 0 = start) and follows
    // the unload until unload_done, checking every read and handshake.
    task automatic run_unload(input bit stall, input bit toggle_bank, input bit glitch,
                              input logic exp_bank);
        int          nrd = 0, nhs = 0, first_rd = -1, first_v = -1, done_c = -1;
        logic        pv = 1'b0, pl = 1'b0;
        logic [31:0] pd = '0;
        logic [4:0]  pi = '0;
        logic [31:0] base;
        base = exp_bank ? 32'h1000 : 32'h2000;

        @(negedge clk); fft_done = 1'b0; out_ready = 1'b1;
        @(negedge clk); fft_done = 1'b1; #1;
        check("idle_before_start", {rd_en, busy}, 2'b00);

        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (toggle_bank) bank_select = ~bank_select;
            if (glitch && c == 10) fft_done = 1'b0;
            if (glitch && c == 11) fft_done = 1'b1;
            #1;
            if (first_rd < 0 && rd_en) first_rd = c;
            if (first_v < 0 && out_valid) first_v = c;

            if (rd_en) begin
                check("rd_address", rd_address, bitrev5(nrd[4:0]));
                check("rd_address_lin", rd_address_l, nrd[4:0]);
                nrd++;
            end else if (nrd == 32) begin
                check("rd_address_hold", {rd_address, rd_address_l}, {5'd31, 5'd31});
            end
            if (busy) check("rd_bank", rd_bank, exp_bank);

            if (pv) begin
                check("stall_stable", {out_valid, out_data, out_index, out_last},
                      {1'b1, pd, pi, pl});
            end
            if (out_valid && out_ready) begin
                check("out_index", out_index, nhs[4:0]);
                check("out_data", out_data, base + {27'd0, bitrev5(nhs[4:0])});
                check("out_last", out_last, (nhs == 31));
                check("out_lin", {out_data_l, out_index_l}, {base + nhs, nhs[4:0]});
                nhs++;
            end
            pv = out_valid & ~out_ready;
            pd = out_data; pi = out_index; pl = out_last;

            if (unload_done) begin
                done_c = c;
                check("busy_at_done", busy, 1'b0);
                break;
            end
        end

        check("read_count", nrd, 32);
        check("handshake_count", nhs, 32);
        check("first_rd_en_cycle", first_rd, 1);
        check("first_valid_cycle", first_v, 3);
        if (stall) check("done_seen", (done_c > 0), 1'b1);
        else       check("done_cycle", done_c, 35);

        @(negedge clk); #1;
        check("done_one_cycle", {unload_done, unload_done_l}, 2'b00);
    endtask

    initial begin
        sclr = 1'b1; fft_done = 1'b0; bank_select = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset_state");
        sclr = 1'b0;

        // Full-rate unload from bank 1, both address orders
        run_unload(1'b0, 1'b0, 1'b0, 1'b1);

        // Random backpressure
        run_unload(1'b1, 1'b0, 1'b0, 1'b1);

        // fft_done high across reset release does not start
        @(negedge clk); fft_done = 1'b1; sclr = 1'b1;
        @(negedge clk);
        @(negedge clk); sclr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("no_start_level", {busy, rd_en}, 2'b00);
        end
        // Drop and re-raise gives one unload; an edge during it is ignored
        run_unload(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("no_restart", {busy, rd_en, unload_done}, 3'b000);
        end

        // Bank 0 with bank_select toggling every cycle and stalls
        @(negedge clk); bank_select = 1'b0;
        run_unload(1'b1, 1'b1, 1'b0, 1'b0);

        // Abort at bin 10 during its handshake
        @(negedge clk); fft_done = 1'b0; bank_select = 1'b1; out_ready = 1'b1;
        @(negedge clk); fft_done = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk); #1;
            if (out_valid && out_ready && out_index == 5'd10) break;
        end
        check("abort_reach_bin10", {out_valid, out_index}, {1'b1, 5'd10});
        sclr = 1'b1;
        @(negedge clk); sclr = 1'b0; #1;
        check_zero_outputs("abort_zero");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("abort_quiet", {busy, unload_done, out_valid}, 3'b000);
        end
        // Fresh unload starts again from bin 0
        run_unload(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
